// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Brief    : Fetch-stage bundle: imem handshake, decode/EX controls, IF/ID regs.
// Revision : 1.0
// ============================================================================
interface if_stage_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               id_stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               if_id_valid;
    logic [INSTR_W-1:0] if_id_instr;
    logic [PC_W-1:0]    if_id_pc;

    modport master (
        output imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc,
        input  imem_ready, imem_rdata, id_stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc,
        output imem_ready, imem_rdata, id_stall, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch: PC, imem handshake, IF/ID register, hold buffer.
// Revision : 1.0
// ============================================================================
module if_stage #(
    parameter int                   PC_W      = 8,
    parameter int                   INSTR_W   = 8,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    if_stage_if.master  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_if_pc;
    logic [INSTR_W-1:0] r_hold_instr;
    logic [PC_W-1:0]    r_hold_pc;

    logic               w_req;
    logic               w_xfer;
    logic [PC_W-1:0]    w_pc_inc;

    // Request is decoded from state so reset drops it without a clock edge.
    assign w_req    = (r_state == S_REQ);
    assign w_xfer   = w_req & bus.imem_ready;
    assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.if_id_valid = r_valid;
    assign bus.if_id_instr = r_instr;
    assign bus.if_id_pc    = r_if_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_if_pc      <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else if (bus.redirect) begin
            // Any transfer completing this cycle is wrong-path and dropped.
            r_state      <= S_REQ;
            r_pc         <= bus.redirect_pc;
            r_valid      <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (w_xfer && !bus.id_stall) begin
                        r_valid <= 1'b1;
                        r_instr <= bus.imem_rdata;
                        r_if_pc <= r_pc;
                        r_pc    <= w_pc_inc;
                    end else if (w_xfer) begin
                        r_hold_instr <= bus.imem_rdata;
                        r_hold_pc    <= r_pc;
                        r_pc         <= w_pc_inc;
                        r_state      <= S_HOLD;
                    end else if (!bus.id_stall) begin
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!bus.id_stall) begin
                        r_valid <= 1'b1;
                        r_instr <= r_hold_instr;
                        r_if_pc <= r_hold_pc;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed self-checking bench for if_stage; memory[i] = i + 8'h10.
// Revision : 1.0
// ============================================================================
module tb_if_stage;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    if_stage_if #(.PC_W(8), .INSTR_W(8)) u_bus ();

    if_stage #(
        .PC_W      (8),
        .INSTR_W   (8),
        .RESET_PC  (8'h00),
        .NOP_INSTR (8'h00)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus.master)
    );

    assign u_bus.imem_rdata = u_bus.imem_addr + 8'h10;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [7:0] ins,
                            input logic [7:0] pc, input logic [7:0] addr);
        chk({tag, "_valid"}, {31'd0, u_bus.if_id_valid}, {31'd0, v});
        chk({tag, "_instr"}, {24'd0, u_bus.if_id_instr}, {24'd0, ins});
        chk({tag, "_pc"},    {24'd0, u_bus.if_id_pc},    {24'd0, pc});
        chk({tag, "_addr"},  {24'd0, u_bus.imem_addr},   {24'd0, addr});
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        u_bus.imem_ready  = 1'b1;
        u_bus.id_stall    = 1'b0;
        u_bus.redirect    = 1'b0;
        u_bus.redirect_pc = 8'h00;
        tick();
        tick();
        chk("rst_req", {31'd0, u_bus.imem_req}, 32'd0);
        chk_ifid("rst", 1'b0, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;

        // Cycle after release stays IDLE, then the first request appears.
        tick();
        chk("first_req", {31'd0, u_bus.imem_req}, 32'd1);
        chk("first_addr", {24'd0, u_bus.imem_addr}, 32'd0);
        chk("first_valid", {31'd0, u_bus.if_id_valid}, 32'd0);

        for (int k = 0; k < 5; k++) begin
            tick();
            chk_ifid("stream", 1'b1, 8'(8'h10 + k), 8'(k), 8'(k + 1));
        end

        // Wait states at address 5
        u_bus.imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_ifid("wait", 1'b0, 8'h00, 8'h04, 8'h05);
            chk("wait_req", {31'd0, u_bus.imem_req}, 32'd1);
        end
        u_bus.imem_ready = 1'b1;
        tick();
        chk_ifid("wait_done", 1'b1, 8'h15, 8'h05, 8'h06);

        // Decode stall: instruction 6 goes to hold, IF/ID frozen on 5
        u_bus.id_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_ifid("stall", 1'b1, 8'h15, 8'h05, 8'h07);
            chk("stall_req", {31'd0, u_bus.imem_req}, 32'd0);
        end
        u_bus.id_stall = 1'b0;
        tick();
        chk_ifid("release", 1'b1, 8'h16, 8'h06, 8'h07);
        chk("release_req", {31'd0, u_bus.imem_req}, 32'd1);

        // Redirect coincident with transfer at pc 7
        u_bus.redirect    = 1'b1;
        u_bus.redirect_pc = 8'h40;
        tick();
        u_bus.redirect = 1'b0;
        chk_ifid("redir", 1'b0, 8'h00, 8'h06, 8'h40);
        tick();
        chk_ifid("redir_tgt", 1'b1, 8'h50, 8'h40, 8'h41);

        // Redirect while in HOLD
        u_bus.id_stall = 1'b1;
        tick();
        chk_ifid("hstall", 1'b1, 8'h50, 8'h40, 8'h42);
        tick();
        u_bus.redirect    = 1'b1;
        u_bus.redirect_pc = 8'h20;
        tick();
        u_bus.redirect = 1'b0;
        chk_ifid("hredir", 1'b0, 8'h00, 8'h40, 8'h20);
        chk("hredir_req", {31'd0, u_bus.imem_req}, 32'd1);
        u_bus.id_stall = 1'b0;
        tick();
        chk_ifid("hredir_tgt", 1'b1, 8'h30, 8'h20, 8'h21);

        // PC wrap
        u_bus.redirect    = 1'b1;
        u_bus.redirect_pc = 8'hFE;
        tick();
        u_bus.redirect = 1'b0;
        chk_ifid("wrap_redir", 1'b0, 8'h00, 8'h20, 8'hFE);
        tick();
        chk_ifid("wrap_fe", 1'b1, 8'h0E, 8'hFE, 8'hFF);
        tick();
        chk_ifid("wrap_ff", 1'b1, 8'h0F, 8'hFF, 8'h00);
        tick();
        chk_ifid("wrap_00", 1'b1, 8'h10, 8'h00, 8'h01);

        // Asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, u_bus.imem_req}, 32'd0);
        chk_ifid("arst", 1'b0, 8'h00, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
